// File: rtl/mouse_pkg.sv
// ============================================================================
// Module   : mouse_pkg
// Brief    : Shared PS/2 mouse packet definitions and screen geometry defaults
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        UPDATE  = 2'd3
    } mouse_state_t;

    // Byte-0 field positions of a standard PS/2 movement packet
    localparam int c_BIT_L    = 0;
    localparam int c_BIT_R    = 1;
    localparam int c_BIT_M    = 2;
    localparam int c_BIT_SYNC = 3;
    localparam int c_BIT_XS   = 4;
    localparam int c_BIT_YS   = 5;
    localparam int c_BIT_XO   = 6;
    localparam int c_BIT_YO   = 7;

    // Screen geometry, also used by the game controller's board layout
    localparam int c_H_MAX = 640;
    localparam int c_V_MAX = 480;

endpackage

`default_nettype wire

// File: rtl/mouse_axis_clamp.sv
// ============================================================================
// Module   : mouse_axis_clamp
// Brief    : Adds a 9-bit signed delta to an axis position and clamps to screen
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_axis_clamp #(
    parameter int AXIS_MAX = 640,
    parameter bit NEGATE   = 1'b0
) (
    input  logic [9:0] position,
    input  logic [8:0] delta,
    input  logic       overflow,
    output logic [9:0] clamped
);

    localparam logic signed [10:0] c_TOP = 11'(AXIS_MAX - 1);

    logic signed [10:0] w_delta;
    logic signed [10:0] w_step;
    logic signed [10:0] w_sum;

    // Negation happens in 11 bits so that a delta of -256 becomes +256 cleanly
    always_comb begin
        w_delta = '0;
        if (!overflow) begin
            w_delta = {{2{delta[8]}}, delta};
        end
        w_step  = NEGATE ? -w_delta : w_delta;
        w_sum   = $signed({1'b0, position}) + w_step;
        clamped = w_sum[9:0];
        if (w_sum < 0) begin
            clamped = '0;
        end else if (w_sum > c_TOP) begin
            clamped = c_TOP[9:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mouse_tracker.sv
// ============================================================================
// Module   : mouse_tracker
// Brief    : PS/2 byte stream to clamped cursor position and left-click pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_tracker
    import mouse_pkg::*;
#(
    parameter int H_MAX          = c_H_MAX,
    parameter int V_MAX          = c_V_MAX,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [9:0] mouseX,
    output logic [9:0] mouseY,
    output logic       mouseBotton,
    output logic       leftHeld,
    output logic       packetError
);

    localparam int                  c_IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);

    mouse_state_t        r_state;
    mouse_state_t        w_nextState;
    logic [c_IDLE_W-1:0] r_idle;
    logic                w_syncErr;
    logic                w_timeout;
    logic                w_acceptB0;

    logic       r_left;
    logic       r_xSign;
    logic       r_ySign;
    logic       r_xOvf;
    logic       r_yOvf;
    logic [7:0] r_dxLow;
    logic [7:0] r_dyLow;

    logic [9:0] r_mouseX;
    logic [9:0] r_mouseY;
    logic       r_mouseBotton;
    logic       r_leftHeld;
    logic       r_packetError;
    logic [9:0] w_nextX;
    logic [9:0] w_nextY;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_B0;
        end else begin
            r_state <= w_nextState;
        end
    end

    // UPDATE shares the WAIT_B0 byte rules so back-to-back packets lose nothing
    always_comb begin
        w_nextState = r_state;
        w_syncErr   = 1'b0;
        w_timeout   = 1'b0;
        w_acceptB0  = 1'b0;
        case (r_state)
            WAIT_B0, UPDATE: begin
                w_nextState = WAIT_B0;
                if (rx_valid) begin
                    if (rx_data[c_BIT_SYNC]) begin
                        w_acceptB0  = 1'b1;
                        w_nextState = WAIT_B1;
                    end else begin
                        w_syncErr = 1'b1;
                    end
                end
            end
            WAIT_B1, WAIT_B2: begin
                if (rx_valid) begin
                    w_nextState = (r_state == WAIT_B1) ? WAIT_B2 : UPDATE;
                end else if (r_idle == c_IDLE_LAST) begin
                    w_timeout   = 1'b1;
                    w_nextState = WAIT_B0;
                end
            end
            default: w_nextState = WAIT_B0;
        endcase
    end

    mouse_axis_clamp #(
        .AXIS_MAX(H_MAX),
        .NEGATE  (1'b0)
    ) u_clampX (
        .position(r_mouseX),
        .delta   ({r_xSign, r_dxLow}),
        .overflow(r_xOvf),
        .clamped (w_nextX)
    );

    // PS/2 reports +Y as up, screen Y grows downward
    mouse_axis_clamp #(
        .AXIS_MAX(V_MAX),
        .NEGATE  (1'b1)
    ) u_clampY (
        .position(r_mouseY),
        .delta   ({r_ySign, r_dyLow}),
        .overflow(r_yOvf),
        .clamped (w_nextY)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle        <= '0;
            r_left        <= 1'b0;
            r_xSign       <= 1'b0;
            r_ySign       <= 1'b0;
            r_xOvf        <= 1'b0;
            r_yOvf        <= 1'b0;
            r_dxLow       <= '0;
            r_dyLow       <= '0;
            r_mouseX      <= 10'(X_INIT);
            r_mouseY      <= 10'(Y_INIT);
            r_mouseBotton <= 1'b0;
            r_leftHeld    <= 1'b0;
            r_packetError <= 1'b0;
        end else begin
            r_packetError <= w_syncErr | w_timeout;
            r_mouseBotton <= 1'b0;

            if ((r_state == WAIT_B1 || r_state == WAIT_B2) && !rx_valid && !w_timeout) begin
                r_idle <= r_idle + 1'b1;
            end else begin
                r_idle <= '0;
            end

            if (w_acceptB0) begin
                r_left  <= rx_data[c_BIT_L];
                r_xSign <= rx_data[c_BIT_XS];
                r_ySign <= rx_data[c_BIT_YS];
                r_xOvf  <= rx_data[c_BIT_XO];
                r_yOvf  <= rx_data[c_BIT_YO];
            end
            if (r_state == WAIT_B1 && rx_valid) begin
                r_dxLow <= rx_data;
            end
            if (r_state == WAIT_B2 && rx_valid) begin
                r_dyLow <= rx_data;
            end

            if (r_state == UPDATE) begin
                r_mouseX      <= w_nextX;
                r_mouseY      <= w_nextY;
                r_leftHeld    <= r_left;
                r_mouseBotton <= r_left & ~r_leftHeld;
            end
        end
    end

    assign mouseX      = r_mouseX;
    assign mouseY      = r_mouseY;
    assign mouseBotton = r_mouseBotton;
    assign leftHeld    = r_leftHeld;
    assign packetError = r_packetError;

endmodule

`default_nettype wire

// File: tb/tb_mouse_tracker.sv
// ============================================================================
// Module   : tb_mouse_tracker
// Brief    : Directed and randomized checks of mouse_tracker against a packet model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mouse_tracker;

    localparam int c_T  = 24;
    localparam int c_H  = 640;
    localparam int c_V  = 480;
    localparam int c_XI = 320;
    localparam int c_YI = 240;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic [9:0] mouseX;
    logic [9:0] mouseY;
    logic       mouseBotton;
    logic       leftHeld;
    logic       packetError;

    mouse_tracker #(
        .H_MAX         (c_H),
        .V_MAX         (c_V),
        .X_INIT        (c_XI),
        .Y_INIT        (c_YI),
        .TIMEOUT_CYCLES(c_T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .mouseX     (mouseX),
        .mouseY     (mouseY),
        .mouseBotton(mouseBotton),
        .leftHeld   (leftHeld),
        .packetError(packetError)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: packet bytes collected so far and the expected outputs
    int         mX, mY, mCnt, mIdle;
    bit         mHeld, mBot, mErr, mPend;
    logic [7:0] p0, p1, p2;

    task automatic check(input string tag, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".x"},    int'(mouseX),      mX);
        check({tag, ".y"},    int'(mouseY),      mY);
        check({tag, ".held"}, int'(leftHeld),    int'(mHeld));
        check({tag, ".btn"},  int'(mouseBotton), int'(mBot));
        check({tag, ".err"},  int'(packetError), int'(mErr));
    endtask

    function automatic int clampInt(input int v, input int maxV);
        if (v < 0) return 0;
        if (v > maxV - 1) return maxV - 1;
        return v;
    endfunction

    task automatic applyPacket();
        int dx, dy;
        dx = int'(p1) - (p0[4] ? 256 : 0);
        dy = int'(p2) - (p0[5] ? 256 : 0);
        if (p0[6]) dx = 0;
        if (p0[7]) dy = 0;
        mX    = clampInt(mX + dx, c_H);
        mY    = clampInt(mY - dy, c_V);
        mBot  = p0[0] && !mHeld;
        mHeld = p0[0];
    endtask

    task automatic modelEdge(input bit v, input logic [7:0] b);
        mErr = 1'b0;
        mBot = 1'b0;
        if (mPend) begin
            applyPacket();
            mPend = 1'b0;
        end
        if (mCnt == 0) begin
            if (v) begin
                if (b[3]) begin
                    p0   = b;
                    mCnt = 1;
                    mIdle = 0;
                end else begin
                    mErr = 1'b1;
                end
            end
        end else if (v) begin
            if (mCnt == 1) begin
                p1   = b;
                mCnt = 2;
            end else begin
                p2    = b;
                mCnt  = 0;
                mPend = 1'b1;
            end
            mIdle = 0;
        end else begin
            mIdle++;
            if (mIdle == c_T) begin
                mErr  = 1'b1;
                mCnt  = 0;
                mIdle = 0;
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] b, input string tag);
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        modelEdge(v, b);
        checkAll(tag);
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        mX = c_XI; mY = c_YI; mCnt = 0; mIdle = 0;
        mHeld = 1'b0; mBot = 1'b0; mErr = 1'b0; mPend = 1'b0;
        check("rst.x",    int'(mouseX), 320);
        check("rst.y",    int'(mouseY), 240);
        check("rst.pulse", int'({mouseBotton, leftHeld, packetError}), 0);
    endtask

    // Three bytes back-to-back, then the UPDATE cycle that publishes the result
    task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input string tag);
        step(1'b1, b0, tag);
        step(1'b1, b1, tag);
        step(1'b1, b2, tag);
        step(1'b0, 8'h00, tag);
    endtask

    initial begin
        int savedX, n;
        bit found;
        logic [7:0] rb0;

        doReset(2);

        pkt(8'h08, 8'h0A, 8'h05, "basic");
        check("basic.X", int'(mouseX), 330);
        check("basic.Y", int'(mouseY), 235);

        pkt(8'h09, 8'h00, 8'h00, "click");
        check("click.pulse", int'(mouseBotton), 1);
        check("click.held",  int'(leftHeld), 1);
        step(1'b0, 8'h00, "click.after");
        check("click.oneCycle", int'(mouseBotton), 0);
        pkt(8'h09, 8'h00, 8'h00, "hold");
        check("hold.noPulse", int'(mouseBotton), 0);
        pkt(8'h08, 8'h00, 8'h00, "release");
        check("release.held", int'(leftHeld), 0);

        doReset(1);
        pkt(8'h18, 8'h00, 8'h00, "clampXa");
        check("clampX.64", int'(mouseX), 64);
        pkt(8'h18, 8'h00, 8'h00, "clampXb");
        check("clampX.0", int'(mouseX), 0);
        pkt(8'h28, 8'h00, 8'h80, "clampYa");
        check("clampY.368", int'(mouseY), 368);
        pkt(8'h28, 8'h00, 8'h80, "clampYb");
        check("clampY.479", int'(mouseY), 479);
        pkt(8'h48, 8'h10, 8'h02, "ovf");
        check("ovf.X", int'(mouseX), 0);
        check("ovf.Y", int'(mouseY), 477);

        step(1'b1, 8'h00, "sync");
        check("sync.err", int'(packetError), 1);
        pkt(8'h08, 8'h01, 8'h00, "syncRecover");
        check("sync.X", int'(mouseX), 1);

        // Sync error arriving in the UPDATE cycle
        step(1'b1, 8'h08, "simul");
        step(1'b1, 8'h03, "simul");
        step(1'b1, 8'h00, "simul");
        step(1'b1, 8'h00, "simul");
        check("simul.X",   int'(mouseX), 4);
        check("simul.err", int'(packetError), 1);

        savedX = int'(mouseX);
        step(1'b1, 8'h08, "tmo");
        step(1'b1, 8'h05, "tmo");
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 3 * c_T && !found; i++) begin
            step(1'b0, 8'h00, "tmo.idle");
            n++;
            if (packetError) found = 1'b1;
        end
        check("tmo.latency", n, c_T);
        check("tmo.X", int'(mouseX), savedX);
        pkt(8'h08, 8'h04, 8'h00, "tmoNext");
        check("tmoNext.X", int'(mouseX), savedX + 4);

        // Gaps just under the limit must not break a packet
        step(1'b1, 8'h08, "slow");
        repeat (c_T - 2) step(1'b0, 8'h00, "slow");
        step(1'b1, 8'h01, "slow");
        repeat (c_T - 2) step(1'b0, 8'h00, "slow");
        step(1'b1, 8'h00, "slow");
        step(1'b0, 8'h00, "slow");
        check("slow.X", int'(mouseX), savedX + 5);

        step(1'b1, 8'h08, "midRst");
        step(1'b1, 8'h30, "midRst");
        doReset(1);
        pkt(8'h08, 8'h02, 8'h00, "afterRst");
        check("afterRst.X", int'(mouseX), 322);

        for (int k = 0; k < 250; k++) begin
            rb0 = 8'($urandom);
            if ($urandom_range(0, 9) != 0) rb0[3] = 1'b1;
            step(1'b1, rb0, "rnd");
            for (int j = 0; j < 2; j++) begin
                n = ($urandom_range(0, 15) == 0) ? $urandom_range(0, c_T + 4)
                                                  : $urandom_range(0, 2);
                repeat (n) step(1'b0, 8'h00, "rnd.gap");
                step(1'b1, 8'($urandom), "rnd");
            end
            if ($urandom_range(0, 1) == 0) step(1'b0, 8'h00, "rnd.tail");
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

`default_nettype wire
